// File: rtl/dm_arbiter.sv
// Data-memory arbiter: the CPU M-stage owns the single-port memory by default and
// a DMA requester gets starvation-bounded, locked, word-aligned bursts.
module dm_arbiter #(
  parameter int STARVE_LIM = 16,
  parameter int BURST_MAX  = 8,
  parameter int DM_WORDS   = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  localparam int              WCW       = $clog2(STARVE_LIM + 1);
  localparam logic [WCW-1:0]  WAIT_LIM  = WCW'(STARVE_LIM);
  localparam logic [31:0]     WRAP_ADDR = 32'(4 * (DM_WORDS - 1));

  typedef enum logic [0:0] {
    CPU_OWN   = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  state_t         state_r,      state_s;
  logic [WCW-1:0] wait_cnt_r,   wait_cnt_s;
  logic [3:0]     beats_r,      beats_s;
  logic [31:0]    burst_addr_r, burst_addr_s;
  logic           burst_we_r,   burst_we_s;
  logic           dma_done_r,   dma_done_s;

  // A zero-length request still moves one word; oversize requests are cut to BURST_MAX.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    logic [3:0] res;
    if (len == 4'd0) begin
      res = 4'd1;
    end else if (32'(len) > BURST_MAX) begin
      res = 4'(BURST_MAX);
    end else begin
      res = len;
    end
    return res;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    logic [31:0] res;
    if (addr >= WRAP_ADDR) begin
      res = 32'd0;
    end else begin
      res = addr + 32'd4;
    end
    return res;
  endfunction

  // Ownership decision, burst bookkeeping and the memory-port mux.
  always_comb begin
    state_s      = state_r;
    wait_cnt_s   = wait_cnt_r;
    beats_s      = beats_r;
    burst_addr_s = burst_addr_r;
    burst_we_s   = burst_we_r;
    dma_done_s   = 1'b0;
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    dm_addr      = cpu_addr;
    dm_wdata     = cpu_wdata;
    dm_we        = 1'b0;
    dm_pc        = cpu_pc;
    case (state_r)
      CPU_OWN: begin
        cpu_gnt = cpu_req;
        dm_we   = cpu_req & cpu_we;
        if (dma_req && (!cpu_req || (wait_cnt_r == WAIT_LIM))) begin
          state_s      = DMA_BURST;
          wait_cnt_s   = '0;
          burst_addr_s = {dma_addr[31:2], 2'b00};
          burst_we_s   = dma_we;
          beats_s      = clamp_len(dma_len);
        end else if (dma_req) begin
          if (wait_cnt_r != WAIT_LIM) begin
            wait_cnt_s = wait_cnt_r + WCW'(1);
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end else begin
          wait_cnt_s = '0;
        end
      end
      DMA_BURST: begin
        dma_gnt    = dma_req;
        dm_addr    = burst_addr_r;
        dm_wdata   = dma_wdata;
        dm_we      = dma_req & burst_we_r;
        dm_pc      = 32'd0;
        wait_cnt_s = '0;
        if (!dma_req) begin
          // Abort: hand the memory back without consuming a beat.
          state_s = CPU_OWN;
        end else if (beats_r <= 4'd1) begin
          state_s      = CPU_OWN;
          beats_s      = 4'd0;
          burst_addr_s = next_addr(burst_addr_r);
          dma_done_s   = 1'b1;
        end else begin
          beats_s      = beats_r - 4'd1;
          burst_addr_s = next_addr(burst_addr_r);
        end
      end
      default: begin
        state_s    = CPU_OWN;
        wait_cnt_s = '0;
        beats_s    = 4'd0;
      end
    endcase
  end

  // State and burst registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= CPU_OWN;
      wait_cnt_r   <= '0;
      beats_r      <= 4'd0;
      burst_addr_r <= 32'd0;
      burst_we_r   <= 1'b0;
      dma_done_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      beats_r      <= beats_s;
      burst_addr_r <= burst_addr_s;
      burst_we_r   <= burst_we_s;
      dma_done_r   <= dma_done_s;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = dm_rdata;
  assign dma_rdata = dm_rdata;
  assign dma_done  = dma_done_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the ownership rules.
module tb_dm_arbiter;

  localparam int SL = 4;
  localparam int BM = 8;
  localparam int DW = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_len;
  logic        dma_gnt, dma_done;
  logic [31:0] dma_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        dm_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_LIM(SL), .BURST_MAX(BM), .DM_WORDS(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_pc(cpu_pc), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_pc(dm_pc),
    .dm_rdata(dm_rdata)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:DW-1];

  function automatic int widx(input logic [31:0] a);
    return int'(a[31:2]) % DW;
  endfunction

  assign dm_rdata = mem[widx(dm_addr)];

  always @(posedge clk) begin
    if (dm_we) mem[widx(dm_addr)] <= dm_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_pc = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_len = 4'd0; dma_wdata = 32'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h44; cpu_pc = 32'h1234; dma_req = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL reset_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); end
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL reset_dma_done: got %b want 0", dma_done); end
    checks++; if (dm_addr !== 32'h44) begin errors++; $display("FAIL reset_dm_addr: got %h want 44", dm_addr); end
    checks++; if (dm_pc !== 32'h1234) begin errors++; $display("FAIL reset_dm_pc: got %h want 1234", dm_pc); end
  endtask

  task automatic test_cpu_only;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
    settle();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL cpu_store_gnt: got %b want 1", cpu_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_store_stall: got %b want 0", cpu_stall); end
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL cpu_store_we: got %b want 1", dm_we); end
    checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL cpu_store_addr: got %h want 10", dm_addr); end
    tick();
    cpu_we = 1'b0;
    settle();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL cpu_load_gnt: got %b want 1", cpu_gnt); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL cpu_load_we: got %b want 0", dm_we); end
    checks++; if (cpu_rdata !== 32'hA5) begin errors++; $display("FAIL cpu_load_data: got %h want a5", cpu_rdata); end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_dma_write;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h103; dma_len = 4'd3;
    settle();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL dmaw_decision_gnt: got %b want 0", dma_gnt); end
    tick();
    for (int i = 0; i < 3; i++) begin
      dma_wdata = 32'h1000 + 32'(i);
      settle();
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL dmaw_gnt beat %0d: got %b want 1", i, dma_gnt); end
      checks++; if (dm_addr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL dmaw_addr beat %0d: got %h want %h", i, dm_addr, 32'h100 + 32'(4 * i)); end
      checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL dmaw_we beat %0d: got %b want 1", i, dm_we); end
      checks++; if (dm_pc !== 32'd0) begin errors++; $display("FAIL dmaw_pc beat %0d: got %h want 0", i, dm_pc); end
      tick();
    end
    dma_req = 1'b0;
    settle();
    checks++; if (dma_done !== 1'b1) begin errors++; $display("FAIL dmaw_done: got %b want 1", dma_done); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL dmaw_after_gnt: got %b want 0", dma_gnt); end
    tick();
    settle();
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL dmaw_done_width: got %b want 0", dma_done); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[32'h40 + i] !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL dmaw_mem word %0d: got %h want %h", i, mem[32'h40 + i], 32'h1000 + 32'(i)); end
    end
    tick();
  endtask

  task automatic test_starvation;
    int first;
    int stalls;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_len = 4'd3;
    first = -1;
    stalls = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) dma_req = 1'b0;
      settle();
      if (dma_gnt === 1'b1 && first < 0) first = c;
      if (cpu_stall === 1'b1) stalls++;
      if (c == 8) begin
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL starve_cpu_resume: got %b want 1", cpu_gnt); end
        checks++; if (dma_done !== 1'b1) begin errors++; $display("FAIL starve_done: got %b want 1", dma_done); end
      end
      tick();
    end
    checks++; if (first != SL + 1) begin errors++; $display("FAIL starve_first_gnt: got %0d want %0d", first, SL + 1); end
    checks++; if (stalls != 3) begin errors++; $display("FAIL starve_stall_cycles: got %0d want 3", stalls); end
    cpu_req = 1'b0;
  endtask

  task automatic test_wrap_clamp;
    logic [31:0] exp_addr;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h2FF8; dma_len = 4'd15;
    settle();
    tick();
    for (int i = 0; i < BM; i++) begin
      dma_wdata = 32'(i);
      exp_addr = 32'(((32'h2FF8 / 4 + i) % DW) * 4);
      settle();
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL wrap_gnt beat %0d: got %b want 1", i, dma_gnt); end
      checks++; if (dm_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr beat %0d: got %h want %h", i, dm_addr, exp_addr); end
      tick();
    end
    dma_req = 1'b0;
    settle();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL clamp_gnt_end: got %b want 0", dma_gnt); end
    checks++; if (dma_done !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b want 1", dma_done); end
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h300; dma_len = 4'd5;
    settle();
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL abort_beat_gnt %0d: got %b want 1", i, dma_gnt); end
      tick();
    end
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
    settle();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL abort_gnt: got %b want 0", dma_gnt); end
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b want 0", dm_we); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL abort_cpu_stall: got %b want 1", cpu_stall); end
    tick();
    settle();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL abort_cpu_back: got %b want 1", cpu_gnt); end
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", dma_done); end
    tick();
    settle();
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL abort_no_done_late: got %b want 0", dma_done); end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    int first;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h400; dma_len = 4'd6;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_req = 1'b1;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (c == 0) begin
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_cpu_gnt: got %b want 1", cpu_gnt); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_dma_gnt: got %b want 0", dma_gnt); end
        checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", dma_done); end
      end
      if (dma_gnt === 1'b1 && first < 0) begin
        first = c;
        dma_req = 1'b0;
      end
      tick();
    end
    checks++; if (first != SL + 1) begin errors++; $display("FAIL rstmid_wait_cleared: got %0d want %0d", first, SL + 1); end
    cpu_req = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h500; dma_len = 4'd1;
    settle();
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL simul_cpu_gnt: got %b want 1", cpu_gnt); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL simul_dma_wait: got %b want 0", dma_gnt); end
    tick();
    cpu_req = 1'b0;
    settle();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL simul_decision: got %b want 0", dma_gnt); end
    tick();
    settle();
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL simul_dma_gnt: got %b want 1", dma_gnt); end
    checks++; if (dm_addr !== 32'h500) begin errors++; $display("FAIL simul_addr: got %h want 500", dm_addr); end
    tick();
    dma_req = 1'b0;
    settle();
    checks++; if (dma_done !== 1'b1) begin errors++; $display("FAIL simul_done: got %b want 1", dma_done); end
    tick();
  endtask

  task automatic test_random;
    bit          own;
    bit          bwe;
    bit          done_pend;
    int          wcnt;
    int          n;
    logic [31:0] q[$];
    logic        e_cpu_gnt, e_dma_gnt, e_we;
    logic [31:0] e_addr;
    do_reset();
    own = 1'b0; bwe = 1'b0; done_pend = 1'b0; wcnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'($urandom_range(0, 32'h2FFF));
      cpu_wdata = $urandom;
      cpu_pc    = $urandom;
      dma_wdata = $urandom;
      if (!dma_req) begin
        if ($urandom_range(0, 3) == 0) begin
          dma_req  = 1'b1;
          dma_we   = 1'($urandom_range(0, 1));
          dma_addr = 32'($urandom_range(0, 32'h2FFF));
          dma_len  = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dma_req = 1'b0;
      end
      e_cpu_gnt = own ? 1'b0 : cpu_req;
      e_dma_gnt = own ? dma_req : 1'b0;
      e_we      = own ? (dma_req & bwe) : (cpu_req & cpu_we);
      e_addr    = own ? q[0] : cpu_addr;
      settle();
      checks++; if (cpu_gnt !== e_cpu_gnt) begin errors++; $display("FAIL rnd_cpu_gnt cyc %0d: got %b want %b", cyc, cpu_gnt, e_cpu_gnt); end
      checks++; if (dma_gnt !== e_dma_gnt) begin errors++; $display("FAIL rnd_dma_gnt cyc %0d: got %b want %b", cyc, dma_gnt, e_dma_gnt); end
      checks++; if (dm_we !== e_we) begin errors++; $display("FAIL rnd_dm_we cyc %0d: got %b want %b", cyc, dm_we, e_we); end
      checks++; if (dm_addr !== e_addr) begin errors++; $display("FAIL rnd_dm_addr cyc %0d: got %h want %h", cyc, dm_addr, e_addr); end
      checks++; if (dma_done !== done_pend) begin errors++; $display("FAIL rnd_dma_done cyc %0d: got %b want %b", cyc, dma_done, done_pend); end
      checks++; if (cpu_stall !== (cpu_req & ~e_cpu_gnt)) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, cpu_stall, cpu_req & ~e_cpu_gnt); end
      // Advance the reference model across the coming edge.
      done_pend = 1'b0;
      if (!own) begin
        if (dma_req && (!cpu_req || wcnt == SL)) begin
          n = (dma_len == 4'd0) ? 1 : ((int'(dma_len) > BM) ? BM : int'(dma_len));
          q.delete();
          for (int k = 0; k < n; k++) q.push_back(32'(((int'(dma_addr[31:2]) + k) % DW) * 4));
          bwe = dma_we;
          own = 1'b1;
          wcnt = 0;
        end else if (dma_req) begin
          wcnt = (wcnt < SL) ? wcnt + 1 : SL;
        end else begin
          wcnt = 0;
        end
      end else if (!dma_req) begin
        own = 1'b0;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          own = 1'b0;
          done_pend = 1'b1;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DW; i++) mem[i] = 32'd0;
    idle_inputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_cpu_only();
    test_dma_write();
    test_starvation();
    test_wrap_clamp();
    test_abort();
    test_reset_mid_burst();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Arbiter and burst sequencer that shares the single-port data memory (3072 words, combinational read, write on posedge) between the pipeline's M-stage and a DMA/loader requester. The CPU has priority. A starvation counter guarantees the DMA a locked burst. The arbiter generates the word-aligned DMA burst addresses and stalls the pipeline while the DMA owns the memory. It sits between the M-stage/DMA port and the data memory's address, write-data, write-enable and pc inputs.

## Interface
- STARVE_LIM, default 16: number of consecutive blocked cycles after which the DMA pre-empts the CPU (≥1).
- BURST_MAX, default 8: maximum number of beats per DMA burst (≥1).
- DM_WORDS, default 3072: data memory depth in words. Sets the address wrap point.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  M-stage memory access request (load or store).
- cpu_we  in  1  M-stage store.
- cpu_addr  in  32  M-stage byte address.
- cpu_wdata  in  32  M-stage store data.
- cpu_pc  in  32  M-stage PC, forwarded for the store trace.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_stall  out  1  equals cpu_req & ~cpu_gnt; freezes the pipeline.
- cpu_rdata  out  32  equals dm_rdata.
- dma_req  in  1  DMA burst request; held high for the whole burst.
- dma_we  in  1  burst direction (1 = write); sampled at burst start.
- dma_addr  in  32  burst base byte address; sampled at burst start.
- dma_len  in  4  beat count; sampled at burst start.
- dma_wdata  in  32  write data for the current beat.
- dma_gnt  out  1  current beat accepted.
- dma_rdata  out  32  equals dm_rdata.
- dma_done  out  1  one-cycle pulse, the cycle after the last beat.
- dm_addr  out  32  to the memory address port.
- dm_wdata  out  32  to the memory data input.
- dm_we  out  1  to the memory write enable.
- dm_pc  out  32  to the memory pc input.
- dm_rdata  in  32  memory read data.

## Operation
- Two states: CPU_OWN (the reset state) and DMA_BURST.
- **CPU_OWN:**
  - The memory mux selects the CPU: dm_addr=cpu_addr, dm_wdata=cpu_wdata, dm_we=cpu_req&cpu_we, dm_pc=cpu_pc.
  - cpu_gnt=cpu_req; dma_gnt=0.
- **wait_cnt:**
  - In CPU_OWN, increments (saturating at STARVE_LIM) each cycle that dma_req=1 and cpu_req=1.
  - Clears when dma_req=0 and on entry to DMA_BURST.
- **CPU_OWN → DMA_BURST** at the clock edge when dma_req=1 and (cpu_req=0 or wait_cnt==STARVE_LIM).
- **On that edge, latch the burst:**
  - burst_addr = {dma_addr[31:2],2'b00}.
  - burst_we = dma_we.
  - beats = dma_len, with 0 treated as 1 and values >BURST_MAX clamped to BURST_MAX.
- **DMA_BURST:**
  - The memory mux selects the DMA: dm_addr=burst_addr, dm_wdata=dma_wdata, dm_we=dma_req&burst_we, dm_pc=0.
  - dma_gnt=dma_req; cpu_gnt=0, so cpu_stall=cpu_req.
- **Each accepted beat:**
  - beats decrements.
  - burst_addr advances by 4. It wraps from 4*(DM_WORDS-1) (0x2FFC) to 0.
- **Last accepted beat** (beats==1): return to CPU_OWN, and register dma_done=1 for the following cycle.
- **Abort:** dma_req=0 while in DMA_BURST returns the arbiter to CPU_OWN on the next edge. No beat is consumed and dma_done stays 0.
- **Ownership:** the CPU and the DMA never both drive dm_we in the same cycle.

## Timing
- **Reset values:** state=CPU_OWN, wait_cnt=0, beats=0, burst_addr=0, dma_done=0, dma_gnt=0.
  - cpu_gnt follows cpu_req combinationally from the first cycle after reset.
- **Combinational outputs:** grants and the memory mux depend only on the current state and the inputs. A granted write commits at the same clock edge, and read data is valid in the same cycle.
- **Ownership-change latency:** one edge. In the decision cycle the CPU is still granted if cpu_req=1.
- **Worst-case DMA wait** with the CPU continuously requesting: STARVE_LIM+1 cycles from dma_req rising to the first dma_gnt.
- **Worst-case CPU stall:** BURST_MAX cycles per burst.
- **dma_done:** asserted exactly 1 cycle, the cycle after the last beat. In that cycle the state is already CPU_OWN.
- **Reset mid-burst:** the next cycle is CPU_OWN, the burst is dropped and no dma_done is produced.
- **dma_req held high after dma_done:** a new burst can start only through the normal CPU_OWN rule, i.e. at least one CPU_OWN cycle separates bursts.

## Test plan
- **CPU only:** store sequence cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xA5, then a load from 0x10.
  - Required: cpu_gnt=1 and cpu_stall=0 every cycle; the load returns 0xA5.
- **Idle CPU, DMA write:** dma_len=3, dma_addr=0x103 (unaligned), dma_we=1.
  - Required: enter DMA_BURST after 1 edge; writes to 0x100, 0x104, 0x108 on consecutive cycles.
  - dma_done pulses the following cycle.
- **Starvation, STARVE_LIM=4:** cpu_req held at 1, dma_req=1 from cycle 0.
  - Required: first dma_gnt at cycle 5; cpu_stall=1 for exactly dma_len cycles, then cpu_gnt resumes.
- **Wrap and clamp:** dma_addr=0x2FF8, dma_len=15, BURST_MAX=8.
  - Required: 8 beats at 0x2FF8, 0x2FFC, 0x0000, … 0x0014.
- **Abort and reset:**
  - dma_req dropped after 2 of 5 beats → CPU_OWN next cycle, no dma_done.
  - reset during a burst → CPU_OWN, dma_done=0, wait_cnt=0.
- **Simultaneous request at idle:** cpu_req and dma_req rise in the same cycle with wait_cnt=0.
  - Required: the CPU is granted; the DMA waits until cpu_req drops or STARVE_LIM is reached.
